mvm_param_stream: RTL and testbench

Parametrised matrix-vector multiplier, successor to the fixed-size generated `mvm_<K>_..._<B>_...` blocks. It loads a K×K signed matrix and a K-element signed vector serially through one data port, then computes y = A·x on P parallel MAC lanes. It saturates each result to 2B bits, optionally applies ReLU, and streams the K results out under a valid/ready handshake. It sits between the serial operand loader and the downstream result consumer.

---
 rtl/mvm_param_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_mvm_param_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_param_stream.sv
// mvm_param_stream: serially loaded K x K signed matrix-vector multiplier.
// P MAC lanes, saturating/ReLU result stage, valid/ready result stream.
module mvm_param_stream #(
    parameter int K = 32,
    parameter int B = 8,
    parameter int P = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_matrix,
    input  logic                   load_vector,
    input  logic                   in_valid,
    input  logic signed [B-1:0]    data_in,
    input  logic                   start,
    input  logic                   relu,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [2*B-1:0]  data_out,
    output logic [$clog2(K)-1:0]   out_index,
    output logic                   sat
);

    localparam int KW  = $clog2(K);
    localparam int MW  = $clog2(K * K);
    localparam int NG  = K / P;
    localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
    localparam int RW  = 2 * B;
    localparam int ACW = RW + KW;

    localparam logic signed [ACW-1:0] SMAX =
        {{(ACW-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SMIN =
        {{(ACW-RW+1){1'b1}}, {(RW-1){1'b0}}};
    localparam logic signed [RW-1:0] RMAX = {1'b0, {(RW-1){1'b1}}};
    localparam logic signed [RW-1:0] RMIN = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_V,
        S_COMPUTE,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [MW-1:0] cnt_q;
    logic [KW-1:0] col_q;
    logic [GW-1:0] grp_q;
    logic [KW-1:0] idx_q;
    logic          relu_q;
    logic          sat_q;
    logic          done_q;

    // Operand and result storage carry no reset; contents survive runs.
    logic signed [B-1:0]   mat_q  [K*K];
    logic signed [B-1:0]   vec_q  [K];
    logic signed [RW-1:0]  rbuf_q [K];
    logic signed [ACW-1:0] acc_q  [P];

    logic [KW-1:0]         row    [P];
    logic signed [RW-1:0]  prod   [P];
    logic signed [ACW-1:0] acc_in [P];
    logic signed [ACW-1:0] sum    [P];
    logic signed [RW-1:0]  res    [P];
    logic [P-1:0]          lane_sat;

    logic load_last;
    logic grp_end;
    logic comp_last;
    logic hs;
    logic drain_last;
    logic go_start;

    always_comb begin
        load_last = 1'b0;
        if (state_q == S_LOAD_M) begin
            load_last = in_valid && (cnt_q == MW'(K*K-1));
        end else if (state_q == S_LOAD_V) begin
            load_last = in_valid && (cnt_q == MW'(K-1));
        end
        grp_end    = (col_q == KW'(K-1));
        comp_last  = grp_end && (grp_q == GW'(NG-1));
        hs         = (state_q == S_DRAIN) && out_ready;
        drain_last = hs && (idx_q == KW'(K-1));
        go_start   = (state_q == S_IDLE) && start
                     && !load_matrix && !load_vector;
    end

    always_comb begin
        lane_sat = '0;
        for (int p = 0; p < P; p++) begin
            row[p]  = KW'(int'(grp_q) * P + p);
            prod[p] = RW'(mat_q[MW'(int'(row[p]) * K + int'(col_q))])
                    * RW'(vec_q[col_q]);
            acc_in[p] = (col_q == '0) ? SMAX ^ SMAX : acc_q[p];
            sum[p] = acc_in[p]
                   + {{(ACW-RW){prod[p][RW-1]}}, prod[p]};
            if (sum[p] > SMAX) begin
                res[p]      = RMAX;
                lane_sat[p] = 1'b1;
            end else if (sum[p] < SMIN) begin
                res[p]      = RMIN;
                lane_sat[p] = 1'b1;
            end else begin
                res[p] = sum[p][RW-1:0];
            end
            // ReLU acts on the already clamped value.
            if (relu_q && res[p][RW-1]) begin
                res[p] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_matrix) begin
                    state_d = S_LOAD_M;
                end else if (load_vector) begin
                    state_d = S_LOAD_V;
                end else if (start) begin
                    state_d = S_COMPUTE;
                end
            end
            S_LOAD_M,
            S_LOAD_V: begin
                if (load_last) begin
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (comp_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DRAIN);
        data_out  = out_valid ? rbuf_q[idx_q] : '0;
        out_index = idx_q;
        done      = done_q;
        sat       = sat_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            col_q  <= '0;
            grp_q  <= '0;
            idx_q  <= '0;
            relu_q <= 1'b0;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= drain_last;
            if (go_start) begin
                relu_q <= relu;
                sat_q  <= 1'b0;
            end else if (state_q == S_COMPUTE && grp_end && |lane_sat) begin
                sat_q <= 1'b1;
            end
            case (state_q)
                S_LOAD_M,
                S_LOAD_V: begin
                    if (in_valid) begin
                        cnt_q <= load_last ? '0 : cnt_q + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    col_q <= grp_end ? '0 : col_q + 1'b1;
                    if (grp_end) begin
                        grp_q <= comp_last ? '0 : grp_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (hs) begin
                        idx_q <= drain_last ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    col_q <= '0;
                    grp_q <= '0;
                    idx_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_M && in_valid) begin
            mat_q[cnt_q] <= data_in;
        end
        if (state_q == S_LOAD_V && in_valid) begin
            vec_q[cnt_q[KW-1:0]] <= data_in;
        end
        if (state_q == S_COMPUTE) begin
            for (int p = 0; p < P; p++) begin
                acc_q[p] <= sum[p];
                if (grp_end) begin
                    rbuf_q[row[p]] <= res[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_param_stream.sv
// tb_mvm_param_stream: randomized runs of mvm_param_stream checked against
// a plain-arithmetic y = A*x model with clamp and ReLU.
module tb_mvm_param_stream;

    localparam int K  = 32;
    localparam int B  = 8;
    localparam int P  = 4;
    localparam int RW = 2 * B;
    localparam int KW = $clog2(K);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 load_matrix = 1'b0;
    logic                 load_vector = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [B-1:0]  data_in = '0;
    logic                 start = 1'b0;
    logic                 relu = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [RW-1:0] data_out;
    logic [KW-1:0]        out_index;
    logic                 sat;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [B-1:0] ma [K*K];
    logic signed [B-1:0] va [K];
    longint              exp_y [K];
    bit                  exp_sat;

    mvm_param_stream #(.K(K), .B(B), .P(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .start       (start),
        .relu        (relu),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .out_index   (out_index),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, longint obs, longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(bit r);
        longint hi = (longint'(1) <<< (RW - 1)) - 1;
        longint lo = -(longint'(1) <<< (RW - 1));
        exp_sat = 1'b0;
        for (int i = 0; i < K; i++) begin
            longint s = 0;
            for (int c = 0; c < K; c++) begin
                s += longint'(ma[i*K+c]) * longint'(va[c]);
            end
            if (s > hi) begin
                s = hi;
                exp_sat = 1'b1;
            end else if (s < lo) begin
                s = lo;
                exp_sat = 1'b1;
            end
            if (r && s < 0) s = 0;
            exp_y[i] = s;
        end
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < K*K; i++) ma[i] = B'($urandom());
        for (int i = 0; i < K; i++) va[i] = B'($urandom());
    endtask

    task automatic load_mat(int gap, bit with_start);
        load_matrix = 1'b1;
        start = with_start;
        tick();
        load_matrix = 1'b0;
        start = 1'b0;
        for (int i = 0; i < K*K; i++) begin
            repeat ($urandom_range(0, gap)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            data_in  = ma[i];
            if (with_start) begin
                chk("busy_in_load_m", busy, 1);
                chk("no_valid_in_load", out_valid, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("idle_after_load_m", busy, 0);
    endtask

    task automatic load_vec(int gap);
        load_vector = 1'b1;
        tick();
        load_vector = 1'b0;
        for (int i = 0; i < K; i++) begin
            repeat ($urandom_range(0, gap)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            data_in  = va[i];
            tick();
        end
        in_valid = 1'b0;
        chk("idle_after_load_v", busy, 0);
    endtask

    task automatic run(bit r, bit bp, bit chk_lat);
        int lat;
        int nx;
        int guard;
        bit stalled;
        logic signed [RW-1:0] hd;
        logic [KW-1:0] hx;
        model(r);
        out_ready = !bp;
        relu  = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        relu  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 2000) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            chk("timeout_out_valid", 0, 1);
            return;
        end
        if (chk_lat) chk("first_valid_latency", lat, K*K/P + 1);
        nx = 0;
        guard = 0;
        stalled = 1'b0;
        hd = '0;
        hx = '0;
        while (nx < K && guard < 4000) begin
            chk("valid_in_drain", out_valid, 1);
            chk("done_in_drain", done, 0);
            if (stalled) begin
                chk("hold_data", data_out, hd);
                chk("hold_index", out_index, hx);
            end
            chk($sformatf("y[%0d]", nx), data_out, exp_y[nx]);
            chk("out_index", out_index, nx);
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            stalled = !out_ready;
            hd = data_out;
            hx = out_index;
            if (out_ready) nx++;
            tick();
            guard++;
        end
        out_ready = 1'b0;
        if (nx < K) begin
            chk("timeout_drain", nx, K);
            return;
        end
        chk("done_pulse", done, 1);
        chk("busy_after_run", busy, 0);
        chk("valid_after_run", out_valid, 0);
        chk("sat_flag", sat, exp_sat);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_data", data_out, 0);
        chk("rst_index", out_index, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < K*K; i++) ma[i] = (i / K == i % K) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < K; i++) va[i] = B'(i - 16);
        load_mat(0, 1'b0);
        load_vec(0);
        run(1'b0, 1'b0, 1'b1);

        rand_ops();
        load_mat(3, 1'b0);
        load_vec(3);
        run(1'b0, 1'b1, 1'b0);
        rand_ops();
        load_vec(3);
        load_mat(2, 1'b0);
        run(1'b0, 1'b1, 1'b0);
        run(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < K*K; i++) ma[i] = -8'sd128;
        for (int i = 0; i < K; i++) va[i] = -8'sd128;
        load_mat(0, 1'b0);
        load_vec(1);
        run(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < K; i++) va[i] = '0;
        load_vec(0);
        run(1'b0, 1'b1, 1'b0);

        rand_ops();
        load_mat(1, 1'b0);
        load_vec(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", data_out, 0);
        repeat (3) begin
            tick();
            chk("midrst_no_done", done, 0);
            chk("midrst_stay_idle", busy, 0);
        end
        load_mat(1, 1'b0);
        load_vec(1);
        run(1'b0, 1'b1, 1'b0);

        rand_ops();
        load_mat(0, 1'b1);
        chk("start_ignored_valid", out_valid, 0);
        load_vec(0);
        run(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
